// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//   Shared types and defaults for the MEM-stage data-memory responder.
//   - dmem_state_t : responder FSM states
//   - dmem_req_t   : captured load/store request
//   - cnt_width()  : width of the latency down-counter for a given max latency
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int DMEM_ADDR_W = 9;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_DEPTH  = 128;
  localparam int DMEM_RD_LAT = 2;
  localparam int DMEM_WR_LAT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic                   write;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

  // The counter is loaded with LAT-1, so it must hold values up to max_lat-1.
  function automatic int cnt_width(input int max_lat);
    return (max_lat < 2) ? 1 : $clog2(max_lat);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// -----------------------------------------------------------------------------
// dmem_if
//   MEM-stage data port between the pipeline (master) and the data-memory
//   responder (slave).
//   Request : req_valid, req_write, req_addr, req_wdata   (master -> slave)
//   Control : req_ready, stall_o                          (slave  -> master)
//   Response: rsp_valid, rsp_err, rsp_rdata               (slave  -> master)
// -----------------------------------------------------------------------------
interface dmem_if #(
  parameter int ADDR_W = dmem_pkg::DMEM_ADDR_W,
  parameter int DATA_W = dmem_pkg::DMEM_DATA_W
);

  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              stall_o;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, stall_o, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, stall_o, rsp_valid, rsp_err, rsp_rdata
  );

endinterface

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
//   DEPTH x DATA_W data storage with a synchronous write port and a
//   synchronous read whose output register holds its value until the next
//   read or clear.
//   clk, rst_n   : clock / async active-low reset (read register only)
//   we, wdata    : write wdata into word addr at the clock edge
//   re           : load word addr into the read register at the clock edge
//   rclr         : clear the read register (error load); wins over re
//   addr         : word index shared by read and write (one access in flight)
//   rdata        : read register output
// -----------------------------------------------------------------------------
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int IDX_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic              rclr,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // NOTE: storage words carry no reset; only the read register is reset,
  // so the array maps onto plain RAM and survives a pipeline reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rclr) begin
      rdata_d = '0;
    end else if (re) begin
      rdata_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Memory-side responder for the MEM-stage data port. Accepts one load/store
//   at a time, models a multi-cycle SRAM (RD_LAT / WR_LAT cycles), returns a
//   one-cycle response pulse and freezes the pipeline via stall_o while an
//   access is in flight.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset (0 = in reset)
//   bus   : dmem_if slave modport (request, stall/ready, response)
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W,
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int RD_LAT = DMEM_RD_LAT,
  parameter int WR_LAT = DMEM_WR_LAT
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int IDX_W   = ADDR_W - 2;
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = cnt_width(MAX_LAT);

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dmem_req_t        req_q, req_d;
  logic             err_q, err_d;

  dmem_req_t        cur_req;
  logic [IDX_W-1:0] cur_idx;
  logic             addr_bad;
  logic             lat_is_one;
  logic             to_resp;
  logic             mem_we, mem_re, mem_rclr;
  logic [DATA_W-1:0] mem_rdata;

  // In IDLE the live bus is the request being accepted; afterwards the
  // captured copy is used so the pipeline may change its inputs freely.
  always_comb begin
    cur_req = req_q;
    if (state_q == IDLE) begin
      cur_req.write = bus.req_write;
      cur_req.addr  = bus.req_addr;
      cur_req.wdata = bus.req_wdata;
    end
  end

  assign cur_idx    = cur_req.addr[ADDR_W-1:2];
  assign addr_bad   = (cur_req.addr[1:0] != 2'b00) ||
                      ({{(32-IDX_W){1'b0}}, cur_idx} >= 32'(DEPTH));
  assign lat_is_one = cur_req.write ? (WR_LAT == 1) : (RD_LAT == 1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          req_d = cur_req;
          err_d = addr_bad;
          if (addr_bad || lat_is_one) begin
            state_d = RESP;
            cnt_d   = '0;
          end else begin
            state_d = BUSY;
            cnt_d   = cur_req.write ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);
          end
        end
      end
      BUSY: begin
        // BUSY lasts LAT-1 cycles: leave as the decremented count hits zero.
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        // req_valid here is still the completing instruction; ignore it.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Array access: the write commits and the read register loads on the edge
  // into RESP, so read data is visible exactly when rsp_valid rises. A reset
  // before that edge drops the pending write.
  // ---------------------------------------------------------------------------
  assign to_resp  = (state_d == RESP) && (state_q != RESP);
  assign mem_we   = to_resp && !err_d &&  cur_req.write;
  assign mem_re   = to_resp && !err_d && !cur_req.write;
  assign mem_rclr = to_resp &&  err_d && !cur_req.write;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst_n (reset),
    .we    (mem_we),
    .re    (mem_re),
    .rclr  (mem_rclr),
    .addr  (cur_idx),
    .wdata (cur_req.wdata),
    .rdata (mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    // Stall starts combinationally in the accept cycle and drops in RESP.
    bus.stall_o   = (state_q == BUSY) || ((state_q == IDLE) && bus.req_valid);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_err   = (state_q == RESP) && err_q;
  end

  assign bus.rsp_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Directed bench for dmem_responder. dut_a uses the default latencies
//   (RD_LAT=2, WR_LAT=1); dut_b uses WR_LAT=3 for the reset-while-busy case.
//   Inputs change 1ns after the rising edge; outputs are sampled on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int WIN = 6;

  typedef struct {
    logic        ready;
    logic        stall;
    logic        rv;
    logic        err;
    logic [31:0] rdata;
  } smp_t;

  typedef struct {
    int             rsp_at;
    int             rsp_n;
    logic [WIN-1:0] stall_m;
    logic [WIN-1:0] ready_m;
    logic           err;
    logic [31:0]    rdata;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dmem_if bus_a ();
  dmem_if bus_b ();

  dmem_responder dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  dmem_responder #(
    .WR_LAT (3)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // One clock cycle on one DUT: drive inputs, sample on the falling edge,
  // return 1ns after the next rising edge.
  task automatic tick(input bit on_b, input bit v, input bit w,
                      input logic [8:0] a, input logic [31:0] d, output smp_t s);
    if (on_b) begin
      bus_b.req_valid = v; bus_b.req_write = w; bus_b.req_addr = a; bus_b.req_wdata = d;
    end else begin
      bus_a.req_valid = v; bus_a.req_write = w; bus_a.req_addr = a; bus_a.req_wdata = d;
    end
    @(negedge clk);
    if (on_b) begin
      s.ready = bus_b.req_ready; s.stall = bus_b.stall_o; s.rv = bus_b.rsp_valid;
      s.err = bus_b.rsp_err; s.rdata = bus_b.rsp_rdata;
    end else begin
      s.ready = bus_a.req_ready; s.stall = bus_a.stall_o; s.rv = bus_a.rsp_valid;
      s.err = bus_a.rsp_err; s.rdata = bus_a.rsp_rdata;
    end
    @(posedge clk);
    #1;
  endtask

  // Single request (valid for one cycle) observed over a fixed window.
  task automatic access(input bit on_b, input bit w, input logic [8:0] a,
                        input logic [31:0] d, output obs_t o);
    smp_t s;
    o.rsp_at = -1; o.rsp_n = 0; o.stall_m = '0; o.ready_m = '0;
    o.err = 1'bx; o.rdata = 'x;
    for (int c = 0; c < WIN; c++) begin
      tick(on_b, c == 0, w, a, d, s);
      o.stall_m[c] = s.stall;
      o.ready_m[c] = s.ready;
      if (s.rv) begin
        o.rsp_n++;
        if (o.rsp_at < 0) begin
          o.rsp_at = c; o.err = s.err; o.rdata = s.rdata;
        end
      end
    end
  endtask

  task automatic test_reset();
    smp_t sa, sb;
    tick(0, 0, 0, 9'h0, 32'h0, sa);
    tick(1, 0, 0, 9'h0, 32'h0, sb);
    total++;
    if ({sa.ready, sa.stall, sa.rv, sa.err} !== 4'b1000) begin
      bad++; $display("FAIL reset_ctrl_a got=%b exp=1000", {sa.ready, sa.stall, sa.rv, sa.err});
    end
    total++;
    if (sa.rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rdata_a got=%h exp=00000000", sa.rdata);
    end
    total++;
    if ({sb.ready, sb.stall, sb.rv, sb.err} !== 4'b1000 || sb.rdata !== 32'h0) begin
      bad++; $display("FAIL reset_b got=%b/%h exp=1000/00000000", {sb.ready, sb.stall, sb.rv, sb.err}, sb.rdata);
    end
  endtask

  task automatic test_store();
    obs_t o;
    access(0, 1, 9'h010, 32'hDEADBEEF, o);
    total++;
    if (o.rsp_at !== 1 || o.rsp_n !== 1 || o.err !== 1'b0) begin
      bad++; $display("FAIL store_rsp got at=%0d n=%0d err=%b exp at=1 n=1 err=0", o.rsp_at, o.rsp_n, o.err);
    end
    total++;
    if (o.stall_m !== 6'b000001 || o.ready_m !== 6'b111101) begin
      bad++; $display("FAIL store_stall got stall=%b ready=%b exp stall=000001 ready=111101", o.stall_m, o.ready_m);
    end
    total++;
    if (o.rdata !== 32'h0) begin
      bad++; $display("FAIL store_rdata got=%h exp=00000000", o.rdata);
    end
  endtask

  task automatic test_load();
    obs_t o;
    access(0, 0, 9'h010, 32'h0, o);
    total++;
    if (o.rsp_at !== 2 || o.rsp_n !== 1 || o.err !== 1'b0) begin
      bad++; $display("FAIL load_rsp got at=%0d n=%0d err=%b exp at=2 n=1 err=0", o.rsp_at, o.rsp_n, o.err);
    end
    total++;
    if (o.stall_m !== 6'b000011 || o.ready_m !== 6'b111001) begin
      bad++; $display("FAIL load_stall got stall=%b ready=%b exp stall=000011 ready=111001", o.stall_m, o.ready_m);
    end
    total++;
    if (o.rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL load_rdata got=%h exp=deadbeef", o.rdata);
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    access(0, 0, 9'h013, 32'h0, o);
    total++;
    if (o.rsp_at !== 1 || o.err !== 1'b1 || o.rdata !== 32'h0 || o.stall_m !== 6'b000001) begin
      bad++; $display("FAIL misaligned_load got at=%0d err=%b rdata=%h stall=%b exp at=1 err=1 rdata=00000000 stall=000001",
                      o.rsp_at, o.err, o.rdata, o.stall_m);
    end
    access(0, 0, 9'h010, 32'h0, o);
    total++;
    if (o.rdata !== 32'hDEADBEEF || o.err !== 1'b0) begin
      bad++; $display("FAIL word4_intact got=%h err=%b exp=deadbeef err=0", o.rdata, o.err);
    end
    // Misaligned store aimed at word 4: must not write, must not touch rdata.
    access(0, 1, 9'h011, 32'h11111111, o);
    total++;
    if (o.rsp_at !== 1 || o.err !== 1'b1 || o.rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL misaligned_store got at=%0d err=%b rdata=%h exp at=1 err=1 rdata=deadbeef",
                      o.rsp_at, o.err, o.rdata);
    end
    access(0, 0, 9'h010, 32'h0, o);
    total++;
    if (o.rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL word4_after_bad_store got=%h exp=deadbeef", o.rdata);
    end
  endtask

  // Load held valid through its RESP cycle, then a store presented right away.
  task automatic test_back_to_back();
    smp_t s;
    obs_t o;
    logic [WIN-1:0] rdy_m, stl_m, rv_m;
    logic [31:0] rd_c2;
    logic err_c4;
    rdy_m = '0; stl_m = '0; rv_m = '0; rd_c2 = 'x; err_c4 = 1'bx;
    for (int c = 0; c < WIN; c++) begin
      tick(0, c < 4, c == 3, (c == 3) ? 9'h020 : 9'h010, 32'hA5A55A5A, s);
      rdy_m[c] = s.ready; stl_m[c] = s.stall; rv_m[c] = s.rv;
      if (c == 2) rd_c2 = s.rdata;
      if (c == 4) err_c4 = s.err;
    end
    total++;
    if (rv_m !== 6'b010100) begin
      bad++; $display("FAIL b2b_rsp got=%b exp=010100", rv_m);
    end
    total++;
    if (rdy_m !== 6'b101001 || stl_m !== 6'b001011) begin
      bad++; $display("FAIL b2b_ctrl got ready=%b stall=%b exp ready=101001 stall=001011", rdy_m, stl_m);
    end
    total++;
    if (rd_c2 !== 32'hDEADBEEF || err_c4 !== 1'b0) begin
      bad++; $display("FAIL b2b_data got rdata=%h err=%b exp rdata=deadbeef err=0", rd_c2, err_c4);
    end
    access(0, 0, 9'h020, 32'h0, o);
    total++;
    if (o.rdata !== 32'hA5A55A5A || o.rsp_at !== 2) begin
      bad++; $display("FAIL b2b_readback got=%h at=%0d exp=a5a55a5a at=2", o.rdata, o.rsp_at);
    end
  endtask

  task automatic test_reset_midop();
    obs_t o;
    smp_t s;
    int   n_rsp;
    access(1, 1, 9'h010, 32'hDEADBEEF, o);
    total++;
    if (o.rsp_at !== 3 || o.stall_m !== 6'b000111) begin
      bad++; $display("FAIL wrlat3_store got at=%0d stall=%b exp at=3 stall=000111", o.rsp_at, o.stall_m);
    end
    tick(1, 1, 1, 9'h010, 32'h12345678, s);
    bus_b.req_valid = 1'b0;
    #1;
    total++;
    if (bus_b.stall_o !== 1'b1 || bus_b.req_ready !== 1'b0) begin
      bad++; $display("FAIL busy_before_reset got stall=%b ready=%b exp stall=1 ready=0", bus_b.stall_o, bus_b.req_ready);
    end
    reset = 1'b0;
    #1;
    total++;
    if ({bus_b.req_ready, bus_b.stall_o, bus_b.rsp_valid, bus_b.rsp_err} !== 4'b1000 || bus_b.rsp_rdata !== 32'h0) begin
      bad++; $display("FAIL midop_reset_b got=%b/%h exp=1000/00000000",
                      {bus_b.req_ready, bus_b.stall_o, bus_b.rsp_valid, bus_b.rsp_err}, bus_b.rsp_rdata);
    end
    total++;
    if (bus_a.rsp_rdata !== 32'h0) begin
      bad++; $display("FAIL midop_reset_rdata_a got=%h exp=00000000", bus_a.rsp_rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_rsp = 0;
    for (int c = 0; c < 5; c++) begin
      tick(1, 0, 0, 9'h0, 32'h0, s);
      if (s.rv) n_rsp++;
    end
    total++;
    if (n_rsp !== 0) begin
      bad++; $display("FAIL no_rsp_after_reset got=%0d exp=0", n_rsp);
    end
    access(1, 0, 9'h010, 32'h0, o);
    total++;
    if (o.rdata !== 32'hDEADBEEF || o.rsp_at !== 2) begin
      bad++; $display("FAIL dropped_write got=%h at=%0d exp=deadbeef at=2", o.rdata, o.rsp_at);
    end
  endtask

  task automatic test_store_load_b2b();
    smp_t s;
    logic [WIN-1:0] rdy_m, stl_m, rv_m;
    logic [31:0] rd_m [WIN];
    rdy_m = '0; stl_m = '0; rv_m = '0;
    for (int c = 0; c < WIN; c++) begin
      tick(0, (c == 0) || (c == 2), c == 0, 9'h040, 32'h0BADF00D, s);
      rdy_m[c] = s.ready; stl_m[c] = s.stall; rv_m[c] = s.rv; rd_m[c] = s.rdata;
    end
    total++;
    if (rv_m !== 6'b010010 || rdy_m !== 6'b100101 || stl_m !== 6'b001101) begin
      bad++; $display("FAIL st_ld_ctrl got rv=%b ready=%b stall=%b exp rv=010010 ready=100101 stall=001101",
                      rv_m, rdy_m, stl_m);
    end
    total++;
    if (rd_m[1] !== 32'h0) begin
      bad++; $display("FAIL st_ld_store_rdata got=%h exp=00000000", rd_m[1]);
    end
    total++;
    if (rd_m[4] !== 32'h0BADF00D || rd_m[5] !== 32'h0BADF00D) begin
      bad++; $display("FAIL st_ld_load_rdata got=%h/%h exp=0badf00d/0badf00d", rd_m[4], rd_m[5]);
    end
  endtask

  initial begin
    bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
    bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_store();
    test_load();
    test_misaligned();
    test_back_to_back();
    test_reset_midop();
    test_store_load_b2b();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
